mcu_bus_ctrl: RTL and testbench
===============================

Name: mcu_bus_ctrl

Overview:
- Parametrised successor to the MCU parallel-bus slave. Sits between the MCU and the GPU core.
- Samples the MCU bus strobe in the sysclk domain and decodes commands. Assembles a multi-beat address and answers ID and status reads on bus_out.
- Buffers incoming data words, each tagged with an auto-incrementing address, in a FIFO. The core drains the FIFO through a valid/ready handshake.

Parameters:
- BUS_WIDTH, 8, MCU bus width; allowed values 8, 16 or 32; must be ≥8.
- ADDR_WIDTH, 32, address width; integer multiple of BUS_WIDTH.
- FIFO_DEPTH, 16, data FIFO entries; power of two, ≥2.
- AUTO_INC, 1, when 1 the write address increments by 1 after each accepted data word.
- DEVICE_ID, 8'hAE, value returned by GET_ID, zero-extended to BUS_WIDTH.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- busclk  in  1  MCU bus strobe; asynchronous to sysclk.
- bus_in  in  BUS_WIDTH  MCU write bus.
- command_data  in  1  0 = command beat, 1 = data beat.
- bus_out  out  BUS_WIDTH  MCU read bus; registered.
- cmd_strobe  out  1  one-cycle pulse for each command code this block does not handle.
- cmd_code  out  8  code accompanying cmd_strobe; holds until the next strobe.
- address  out  ADDR_WIDTH  committed base address.
- address_strobe  out  1  one-cycle pulse when address is committed.
- data_out  out  BUS_WIDTH  FIFO head word.
- data_addr  out  ADDR_WIDTH  address tag of the FIFO head.
- data_valid  out  1  FIFO not empty.
- data_ready  in  1  consumer accepts the head word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a data word was dropped.

Behaviour:
- **Reset.**
  - Async assert forces all of the following: state IDLE, FIFO empty, write pointer address 0.
  - Outputs at reset: bus_out=0, cmd_strobe=0, cmd_code=0, address=0, address_strobe=0, data_valid=0, fifo_level=0, overflow=0.
  - data_out and data_addr are don't-care while data_valid=0.
- **Synchronisation.**
  - busclk, command_data and bus_in each pass through 2 flops. A third busclk flop drives edge detection: edge = s1 & ~s2.
  - A beat's action is registered on the 3rd sysclk edge that samples busclk high.
  - MCU must hold busclk high and low for ≥3 sysclk periods each. bus_in and command_data must be stable around the rising busclk edge.
- **Command codes** (low 8 bits of bus_in): GET_ID=8'h01, SET_ADDRESS=8'h02, GET_STATUS=8'h03.
- **IDLE state.**
  - Command beat GET_ID: bus_out <= DEVICE_ID in the same action cycle.
  - Command beat GET_STATUS: bus_out <= {overflow, full, empty, level saturated to 5 bits}, upper bits zero. overflow clears in the same cycle.
  - Command beat SET_ADDRESS: go to ADDR; beat counter = 0.
  - Any other command: cmd_code <= code, cmd_strobe=1 for one cycle; stay in IDLE.
  - Data beat: push {bus_in, wr_addr} into the FIFO. If AUTO_INC=1, wr_addr <= wr_addr+1, wrapping modulo 2^ADDR_WIDTH.
- **ADDR state.**
  - Collects N = ADDR_WIDTH/BUS_WIDTH beats, MSB beat first, into a shadow register. Data beats count as address beats.
  - After the Nth beat: address <= shadow and wr_addr <= shadow, address_strobe=1 for one cycle, return to IDLE.
  - A command beat arriving before the Nth beat aborts the sequence. The shadow is discarded, address is unchanged, and that beat is processed as an IDLE command in the same cycle.
- **FIFO.**
  - Pop occurs when data_valid & data_ready; the next head appears the following cycle.
  - Push when full without a simultaneous pop: word dropped, overflow <= 1, wr_addr not incremented.
  - Push and pop in the same cycle when full: push accepted, level unchanged.
  - Push and pop in the same cycle when empty: push accepted; pop ignored because data_valid=0.
  - Entries keep the address tag they had at push time, even if a later SET_ADDRESS changes wr_addr.
- **Read bus.** bus_out holds its last value until the next GET_ID or GET_STATUS.

Test Plan:
- **Reset and ID.** Release reset, then send GET_ID command beat → all outputs 0 before the beat; bus_out=8'hAE 3 sysclk cycles after busclk is sampled high.
- **Address load.** SET_ADDRESS, then data beats 12,34,56,78 (BUS_WIDTH=8) → address=32'h12345678 with a single address_strobe pulse. Then push 8'hA0 and 8'hA1 → data_addr 32'h12345678 and 32'h12345679 in order.
- **Aborted address.** SET_ADDRESS, 2 beats, then command 8'h55 → address unchanged, cmd_strobe pulse with cmd_code=8'h55.
- **Overflow.** Hold data_ready=0 and push 17 words (depth 16) → fifo_level=16, overflow=1, 17th word absent. GET_STATUS → bus_out=8'hD0 (overflow and full set, level saturated to 16) and overflow then clears.
- **Simultaneous push/pop on full.** Full FIFO, data_ready=1 at the push action cycle → level stays 16, no overflow, FIFO order preserved.
- **Reset mid-operation.** Assert reset_n=0 mid-ADDR with FIFO level 5 → immediate return to the reset values above. Next data beat is tagged address 0.

Source files
------------

// File: rtl/mcu_bus_ctrl.sv
// rtl/mcu_bus_ctrl.sv - MCU parallel-bus slave: strobe sync, command decode, address assembly, tagged data FIFO
module mcu_bus_ctrl #(
    parameter int       BUS_WIDTH  = 8,
    parameter int       ADDR_WIDTH = 32,
    parameter int       FIFO_DEPTH = 16,
    parameter bit       AUTO_INC   = 1'b1,
    parameter logic [7:0] DEVICE_ID = 8'hAE
) (
    input  logic                          sysclk,
    input  logic                          reset_n,
    input  logic                          busclk,
    input  logic [BUS_WIDTH-1:0]          bus_in,
    input  logic                          command_data,
    output logic [BUS_WIDTH-1:0]          bus_out,
    output logic                          cmd_strobe,
    output logic [7:0]                    cmd_code,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic                          address_strobe,
    output logic [BUS_WIDTH-1:0]          data_out,
    output logic [ADDR_WIDTH-1:0]         data_addr,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int N_BEATS = ADDR_WIDTH / BUS_WIDTH;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [7:0] CMD_GET_ID      = 8'h01;
    localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;
    localparam logic [7:0] CMD_GET_STATUS  = 8'h03;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } state_t;

    state_t state, next_state;

    // busclk: [0] metastability flop, [1] synchronised level, [2] delayed copy for edge detect
    logic [2:0]           bclk_sync;
    logic                 cd_meta, cd_s;
    logic [BUS_WIDTH-1:0] din_meta, din_s;
    logic                 beat;
    logic [7:0]           code;

    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] shadow, shadow_next;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic do_id, do_status, do_unknown, do_push;
    logic addr_start, addr_beat, addr_done;

    logic [BUS_WIDTH-1:0]  mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [LVL_W-1:0]      count;
    logic                  full, empty, pop, push_ok, push_drop;
    logic [4:0]            level_sat;
    logic [BUS_WIDTH-1:0]  status_word;

    assign beat = bclk_sync[1] & ~bclk_sync[2];
    assign code = din_s[7:0];

    assign full       = (count == LVL_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign data_valid = ~empty;
    assign fifo_level = count;
    assign pop        = data_valid & data_ready;
    assign push_ok    = do_push & (~full | pop);
    assign push_drop  = do_push & full & ~pop;
    assign data_out   = mem_data[rd_ptr];
    assign data_addr  = mem_addr[rd_ptr];

    // Bring the MCU strobe, beat type and bus value into the sysclk domain
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            cd_meta   <= 1'b0;
            cd_s      <= 1'b0;
            din_meta  <= '0;
            din_s     <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], busclk};
            cd_meta   <= command_data;
            cd_s      <= cd_meta;
            din_meta  <= bus_in;
            din_s     <= din_meta;
        end
    end

    // State register
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Beat decode; a command beat always behaves as in IDLE, which also aborts an address load
    always_comb begin
        next_state  = state;
        do_id       = 1'b0;
        do_status   = 1'b0;
        do_unknown  = 1'b0;
        do_push     = 1'b0;
        addr_start  = 1'b0;
        addr_beat   = 1'b0;
        addr_done   = 1'b0;
        shadow_next = (shadow << BUS_WIDTH) | ADDR_WIDTH'(din_s);
        if (beat) begin
            if (!cd_s) begin
                next_state = ST_IDLE;
                case (code)
                    CMD_GET_ID:      do_id = 1'b1;
                    CMD_GET_STATUS:  do_status = 1'b1;
                    CMD_SET_ADDRESS: begin
                        addr_start = 1'b1;
                        next_state = ST_ADDR;
                    end
                    default:         do_unknown = 1'b1;
                endcase
            end else if (state == ST_ADDR) begin
                addr_beat = 1'b1;
                if (beat_cnt == CNT_W'(N_BEATS - 1)) begin
                    addr_done  = 1'b1;
                    next_state = ST_IDLE;
                end
            end else begin
                do_push = 1'b1;
            end
        end
    end

    // Status word: {overflow, full, empty, occupancy saturated to 5 bits}
    always_comb begin
        level_sat   = (32'(count) > 32'd31) ? 5'd31 : 5'(count);
        status_word = '0;
        status_word[7]   = overflow;
        status_word[6]   = full;
        status_word[5]   = empty;
        status_word[4:0] = level_sat;
    end

    // Address assembly, write-address tracking, read bus and command strobes
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt       <= '0;
            shadow         <= '0;
            address        <= '0;
            address_strobe <= 1'b0;
            wr_addr        <= '0;
            cmd_strobe     <= 1'b0;
            cmd_code       <= '0;
            bus_out        <= '0;
            overflow       <= 1'b0;
        end else begin
            address_strobe <= addr_done;
            cmd_strobe     <= do_unknown;
            if (addr_start) begin
                beat_cnt <= '0;
                shadow   <= '0;
            end else if (addr_beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                shadow   <= shadow_next;
            end
            if (addr_done) begin
                address <= shadow_next;
                wr_addr <= shadow_next;
            end else if (push_ok && AUTO_INC) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
            if (do_unknown) begin
                cmd_code <= code;
            end
            if (do_id) begin
                bus_out <= BUS_WIDTH'(DEVICE_ID);
            end else if (do_status) begin
                bus_out <= status_word;
            end
            if (do_status) begin
                overflow <= 1'b0;
            end else if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + LVL_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - LVL_W'(1);
            end
        end
    end

    // FIFO storage; each entry carries the write address current at push time
    always_ff @(posedge sysclk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= din_s;
            mem_addr[wr_ptr] <= wr_addr;
        end
    end

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// tb/tb_mcu_bus_ctrl.sv - directed table-driven bench for mcu_bus_ctrl
module tb_mcu_bus_ctrl;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busclk = 1'b0;
    logic [7:0]  bus_in = '0;
    logic        command_data = 1'b0;
    logic [7:0]  bus_out;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic [31:0] address;
    logic        address_strobe;
    logic [7:0]  data_out;
    logic [31:0] data_addr;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int n_cmd  = 0;
    int n_astb = 0;

    mcu_bus_ctrl dut (
        .sysclk         (sysclk),
        .reset_n        (reset_n),
        .busclk         (busclk),
        .bus_in         (bus_in),
        .command_data   (command_data),
        .bus_out        (bus_out),
        .cmd_strobe     (cmd_strobe),
        .cmd_code       (cmd_code),
        .address        (address),
        .address_strobe (address_strobe),
        .data_out       (data_out),
        .data_addr      (data_addr),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (cmd_strobe)     n_cmd  = n_cmd + 1;
        if (address_strobe) n_astb = n_astb + 1;
    end

    typedef struct {
        logic        cd;
        logic [7:0]  val;
        logic [7:0]  exp_bus;
        logic [7:0]  exp_code;
        logic [4:0]  exp_level;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic cd, input logic [7:0] val, input logic pop_at_action);
        @(posedge sysclk);
        #1;
        command_data = cd;
        bus_in       = val;
        busclk       = 1'b1;
        @(posedge sysclk);
        @(posedge sysclk);
        if (pop_at_action) begin
            @(negedge sysclk);
            data_ready = 1'b1;
        end
        @(posedge sysclk);
        #1 data_ready = 1'b0;
        @(posedge sysclk);
        #1 busclk = 1'b0;
        repeat (4) @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp_d, input logic [31:0] exp_a);
        @(negedge sysclk);
        chk({name, "_valid"}, 32'(data_valid), 32'd1);
        chk({name, "_data"}, 32'(data_out), 32'(exp_d));
        chk({name, "_addr"}, data_addr, exp_a);
        data_ready = 1'b1;
        @(posedge sysclk);
        #1 data_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h40, 8'hAE, 8'h40, 5'd0, 32'h0};
        vecs[1]  = '{1'b0, 8'h03, 8'h20, 8'h40, 5'd0, 32'h0};
        vecs[2]  = '{1'b1, 8'h11, 8'h20, 8'h40, 5'd1, 32'h0};
        vecs[3]  = '{1'b0, 8'h03, 8'h01, 8'h40, 5'd1, 32'h0};
        vecs[4]  = '{1'b0, 8'h02, 8'h01, 8'h40, 5'd1, 32'h0};
        vecs[5]  = '{1'b1, 8'h12, 8'h01, 8'h40, 5'd1, 32'h0};
        vecs[6]  = '{1'b1, 8'h34, 8'h01, 8'h40, 5'd1, 32'h0};
        vecs[7]  = '{1'b1, 8'h56, 8'h01, 8'h40, 5'd1, 32'h0};
        vecs[8]  = '{1'b1, 8'h78, 8'h01, 8'h40, 5'd1, 32'h12345678};
        vecs[9]  = '{1'b1, 8'hA0, 8'h01, 8'h40, 5'd2, 32'h12345678};
        vecs[10] = '{1'b1, 8'hA1, 8'h01, 8'h40, 5'd3, 32'h12345678};
        vecs[11] = '{1'b0, 8'h03, 8'h03, 8'h40, 5'd3, 32'h12345678};

        repeat (3) @(posedge sysclk);
        #1 reset_n = 1'b1;
        @(negedge sysclk);

        chk("rst_bus_out", 32'(bus_out), 32'h0);
        chk("rst_cmd_strobe", 32'(cmd_strobe), 32'h0);
        chk("rst_cmd_code", 32'(cmd_code), 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_address_strobe", 32'(address_strobe), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);

        // GET_ID with exact latency: action on the 3rd edge sampling busclk high
        @(posedge sysclk);
        #1;
        command_data = 1'b0;
        bus_in       = 8'h01;
        busclk       = 1'b1;
        @(posedge sysclk);
        @(posedge sysclk);
        @(negedge sysclk);
        chk("id_before_action", 32'(bus_out), 32'h0);
        @(posedge sysclk);
        @(negedge sysclk);
        chk("id_at_action", 32'(bus_out), 32'hAE);
        @(posedge sysclk);
        #1 busclk = 1'b0;
        repeat (4) @(posedge sysclk);

        for (int i = 0; i < 12; i++) begin
            send_beat(vecs[i].cd, vecs[i].val, 1'b0);
            chk($sformatf("vec%0d_bus_out", i), 32'(bus_out), 32'(vecs[i].exp_bus));
            chk($sformatf("vec%0d_cmd_code", i), 32'(cmd_code), 32'(vecs[i].exp_code));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_address", i), address, vecs[i].exp_addr);
        end
        chk("tbl_cmd_strobes", n_cmd, 1);
        chk("tbl_addr_strobes", n_astb, 1);

        pop_check("drain0", 8'h11, 32'h0);
        pop_check("drain1", 8'hA0, 32'h12345678);
        pop_check("drain2", 8'hA1, 32'h12345679);
        @(negedge sysclk);
        chk("drain_level", 32'(fifo_level), 32'h0);
        chk("drain_valid", 32'(data_valid), 32'h0);

        // Aborted address load
        send_beat(1'b0, 8'h02, 1'b0);
        send_beat(1'b1, 8'h9A, 1'b0);
        send_beat(1'b1, 8'hBC, 1'b0);
        send_beat(1'b0, 8'h55, 1'b0);
        chk("abort_address", address, 32'h12345678);
        chk("abort_cmd_code", 32'(cmd_code), 32'h55);
        chk("abort_cmd_strobes", n_cmd, 2);
        chk("abort_addr_strobes", n_astb, 1);
        send_beat(1'b1, 8'hDD, 1'b0);
        pop_check("abort_tag", 8'hDD, 32'h1234567A);

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_beat(1'b1, 8'h80 + 8'(i), 1'b0);
        end
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        send_beat(1'b0, 8'h03, 1'b0);
        chk("ovf_status", 32'(bus_out), 32'hD0);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        send_beat(1'b0, 8'h03, 1'b0);
        chk("ovf_status2", 32'(bus_out), 32'h50);

        // Push with simultaneous pop while full
        send_beat(1'b1, 8'hE0, 1'b1);
        chk("full_pp_level", 32'(fifo_level), 32'd16);
        chk("full_pp_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            pop_check($sformatf("full_pp_pop%0d", i), 8'h80 + 8'(i), 32'h1234567B + 32'(i));
        end
        pop_check("full_pp_last", 8'hE0, 32'h1234568B);
        @(negedge sysclk);
        chk("full_pp_empty", 32'(fifo_level), 32'd0);

        // Reset in the middle of an address load with 5 words queued
        for (int i = 0; i < 5; i++) begin
            send_beat(1'b1, 8'h30 + 8'(i), 1'b0);
        end
        chk("mid_level5", 32'(fifo_level), 32'd5);
        send_beat(1'b0, 8'h02, 1'b0);
        send_beat(1'b1, 8'h01, 1'b0);
        @(posedge sysclk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_address", address, 32'h0);
        chk("mid_rst_bus_out", 32'(bus_out), 32'h0);
        chk("mid_rst_cmd_code", 32'(cmd_code), 32'h0);
        chk("mid_rst_overflow", 32'(overflow), 32'h0);
        @(posedge sysclk);
        #1 reset_n = 1'b1;
        send_beat(1'b1, 8'h77, 1'b0);
        chk("post_rst_level", 32'(fifo_level), 32'd1);
        pop_check("post_rst_tag", 8'h77, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
